// File: rtl/spart_rx.sv
// SPART receiver: 2-flop synchronised rxd, 8N1 deserialiser driven by a 16x baud enable,
// with a bus-readable byte plus rda / framing / overrun status.
module spart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_baud_en,
  input  logic                 rxd,
  input  logic                 iocs,
  input  logic                 iorw,
  input  logic [1:0]           ioaddr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t               state;
  logic                 rxd_m;
  logic                 rxd_s;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 rd;
  logic                 sample_mid;
  logic                 sample_end;

  always_comb begin
    rd         = iocs & iorw & (ioaddr == 2'b00);
    sample_mid = (sample_cnt == SW'(OVERSAMPLE / 2 - 1));
    sample_end = (sample_cnt == SW'(OVERSAMPLE - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (rd) begin
        rda         <= 1'b0;
        framing_err <= 1'b0;
        overrun     <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state      <= START;
            sample_cnt <= '0;
          end
        end
        START: begin
          if (rx_baud_en) begin
            if (sample_mid) begin
              sample_cnt <= '0;
              bit_cnt    <= '0;
              state      <= rxd_s ? IDLE : DATA;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (rx_baud_en) begin
            if (sample_end) begin
              shift      <= {rxd_s, shift[DATA_BITS-1:1]};
              bit_cnt    <= bit_cnt + 1'b1;
              sample_cnt <= '0;
              if (bit_cnt == BW'(DATA_BITS - 1)) state <= STOP;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (rx_baud_en) begin
            if (sample_end) begin
              // Completion overrides the read-clear above; a coincident read consumed the old byte.
              rx_data     <= shift;
              rda         <= 1'b1;
              framing_err <= ~rxd_s;
              overrun     <= (rda | overrun) & ~rd;
              sample_cnt  <= '0;
              state       <= rxd_s ? IDLE : WAIT_HIGH;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        WAIT_HIGH: begin
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: procedural frame-level reference model compared every cycle,
// directed scenarios pinned with literal expectations, then randomised frames with bus noise.
module tb_spart_rx;

  localparam int unsigned OS       = 16;
  localparam int unsigned DB       = 8;
  localparam int unsigned EN_DIV   = 4;
  localparam int unsigned BIT_CLKS = OS * EN_DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_baud_en = 1'b0;
  logic          rxd = 1'b1;
  logic          iocs = 1'b0;
  logic          iorw = 1'b0;
  logic [1:0]    ioaddr = 2'b00;
  logic [DB-1:0] rx_data;
  logic          rda;
  logic          framing_err;
  logic          overrun;

  spart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_baud_en(rx_baud_en), .rxd(rxd),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .rx_data(rx_data), .rda(rda), .framing_err(framing_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- stimulus: baud enable + bus, driven on negedge ----------------
  bit          noise_on = 0;
  bit          rd_req = 0;
  bit          collide_req = 0;
  int unsigned div = 0;

  initial forever begin
    @(negedge clk);
    div        = (div + 1) % EN_DIV;
    rx_baud_en = (div == 0);
    iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
    if (collide_req && rx_baud_en) begin
      iocs = 1'b1; iorw = 1'b1; collide_req = 0;
    end else if (rd_req) begin
      iocs = 1'b1; iorw = 1'b1; rd_req = 0;
    end else if (noise_on) begin
      iocs   = ($urandom_range(0, 3) == 0);
      iorw   = 1'($urandom_range(0, 1));
      ioaddr = 2'($urandom_range(0, 3));
    end
  end

  // ---------------- reference model ----------------
  logic [1:0]    h = 2'b11;          // rxd as the receiver sees it, two clocks late
  logic [DB-1:0] exp_data = '0;
  logic          exp_rda = 1'b0;
  logic          exp_fe = 1'b0;
  logic          exp_ov = 1'b0;
  logic          m_s;
  bit            abort;
  int            m_phase = 0;
  int unsigned   m_cnt = 0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) h <= 2'b11;
    else        h <= {h[0], rxd};

  function automatic bit bus_rd();
    return iocs && iorw && (ioaddr == 2'b00);
  endfunction

  task automatic step();
    @(posedge clk);
    m_s   = h[1];
    abort = !rst_n;
    if (!rst_n) begin
      exp_data <= '0; exp_rda <= 1'b0; exp_fe <= 1'b0; exp_ov <= 1'b0;
    end else if (bus_rd()) begin
      exp_rda <= 1'b0; exp_fe <= 1'b0; exp_ov <= 1'b0;
    end
  endtask

  task automatic wait_en(input int unsigned k);
    abort = 0;
    m_cnt = 0;
    while (m_cnt < k && !abort) begin
      step();
      if (!abort && rx_baud_en) m_cnt++;
    end
  endtask

  initial begin : model
    logic [DB-1:0] sh;
    sh = '0;
    forever begin
      m_phase = 0;
      do step(); while (abort || m_s);
      m_phase = 1;
      wait_en(OS / 2);
      if (abort || m_s) continue;
      m_phase = 2;
      for (int i = 0; i < DB && !abort; i++) begin
        wait_en(OS);
        sh[i] = m_s;
      end
      if (abort) continue;
      m_phase = 3;
      wait_en(OS);
      if (abort) continue;
      exp_data <= sh;
      exp_rda  <= 1'b1;
      exp_fe   <= !m_s;
      if (!bus_rd() && exp_rda) exp_ov <= 1'b1;
      m_phase = 4;
      if (!m_s) do step(); while (!abort && !m_s);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      check("rst_rx_data", 32'(rx_data), 32'h0);
      check("rst_rda", 32'(rda), 32'h0);
      check("rst_framing_err", 32'(framing_err), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
    end else begin
      check("rx_data", 32'(rx_data), 32'(exp_data));
      check("rda", 32'(rda), 32'(exp_rda));
      check("framing_err", 32'(framing_err), 32'(exp_fe));
      check("overrun", 32'(overrun), 32'(exp_ov));
    end
  end

  logic        rda_prev = 1'b0;
  int unsigned rda_rises = 0;
  always @(posedge clk) begin
    #1;
    if (rda && !rda_prev) rda_rises++;
    rda_prev = rda;
  end

  // ---------------- line drivers ----------------
  task automatic hold(input logic v, input int unsigned clks);
    rxd = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] b, input logic stop_v);
    logic [DB-1:0] bb;
    bb = b;
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < DB; i++) hold(bb[i], BIT_CLKS);
    hold(stop_v, BIT_CLKS);
  endtask

  task automatic do_read();
    rd_req = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [DB-1:0] d, input logic r,
                            input logic fe, input logic ov);
    check({tag, "_data"}, 32'(rx_data), 32'(d));
    check({tag, "_rda"}, 32'(rda), 32'(r));
    check({tag, "_fe"}, 32'(framing_err), 32'(fe));
    check({tag, "_ov"}, 32'(overrun), 32'(ov));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    repeat (5) @(negedge clk);
    expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    hold(1'b1, 2 * BIT_CLKS);

    // clean byte
    send_frame(8'h55, 1'b1);
    hold(1'b1, BIT_CLKS);
    expect_out("clean55", 8'h55, 1'b1, 1'b0, 1'b0);
    check("model_clean55", 32'(exp_data), 32'h55);
    do_read();
    expect_out("read55", 8'h55, 1'b0, 1'b0, 1'b0);

    // false start then a real frame
    hold(1'b0, 6 * EN_DIV);
    hold(1'b1, 2 * BIT_CLKS);
    check("false_start_rda", 32'(rda), 32'h0);
    send_frame(8'hA3, 1'b1);
    hold(1'b1, BIT_CLKS);
    expect_out("a3", 8'hA3, 1'b1, 1'b0, 1'b0);
    do_read();

    // framing error with line held low afterwards
    rda_rises = 0;
    send_frame(8'h3C, 1'b0);
    hold(1'b0, 40 * BIT_CLKS);
    check("break_rda_pulses", rda_rises, 32'd1);
    expect_out("fe3c", 8'h3C, 1'b1, 1'b1, 1'b0);
    check("model_fe3c", 32'(exp_fe), 32'h1);
    hold(1'b1, BIT_CLKS);
    do_read();
    send_frame(8'h81, 1'b1);
    hold(1'b1, BIT_CLKS);
    expect_out("after_break81", 8'h81, 1'b1, 1'b0, 1'b0);
    do_read();

    // overrun
    send_frame(8'h11, 1'b1);
    hold(1'b1, BIT_CLKS);
    send_frame(8'h22, 1'b1);
    hold(1'b1, BIT_CLKS);
    expect_out("overrun22", 8'h22, 1'b1, 1'b0, 1'b1);
    check("model_overrun", 32'(exp_ov), 32'h1);
    do_read();
    expect_out("overrun_read", 8'h22, 1'b0, 1'b0, 1'b0);

    // read lands on the stop-sample cycle
    send_frame(8'h11, 1'b1);
    hold(1'b1, BIT_CLKS);
    fork
      send_frame(8'h22, 1'b1);
      begin
        found = 0;
        for (int k = 0; k < 12 * BIT_CLKS && !found; k++) begin
          @(posedge clk); #2;
          if (m_phase == 3 && m_cnt == OS - 1) found = 1;
        end
        check("collide_stop_reached", 32'(found), 32'h1);
        if (found) collide_req = 1;
      end
    join
    hold(1'b1, BIT_CLKS);
    expect_out("collide22", 8'h22, 1'b1, 1'b0, 1'b0);

    // reset during data bit 4 of 0xF0 (rda still set from previous frame)
    hold(1'b0, BIT_CLKS);
    hold(1'b0, 4 * BIT_CLKS);
    hold(1'b1, BIT_CLKS / 2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    expect_out("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    hold(1'b1, 3 * BIT_CLKS);
    send_frame(8'h0F, 1'b1);
    hold(1'b1, BIT_CLKS);
    expect_out("after_reset0f", 8'h0F, 1'b1, 1'b0, 1'b0);
    do_read();

    // randomised frames with random bus traffic
    noise_on = 1;
    for (int f = 0; f < 20; f++) begin
      logic [DB-1:0] b;
      logic          sv;
      b  = DB'($urandom);
      sv = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) begin
        hold(1'b0, $urandom_range(1, 5 * EN_DIV));
        hold(1'b1, BIT_CLKS);
      end
      send_frame(b, sv);
      if (!sv) hold(1'b0, $urandom_range(1, 5) * BIT_CLKS);
      hold(1'b1, $urandom_range(0, 2) * BIT_CLKS + $urandom_range(0, BIT_CLKS));
    end
    noise_on = 0;
    hold(1'b1, 2 * BIT_CLKS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
